// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the central sequencer: stall
// requests and the committed exception in, stall/flush/redirect controls out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;

  // Pipeline side: raises requests, consumes the controls.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, perf_stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, perf_stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the five-stage core, with stall watchdog.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FLUSH = 1'b1;
  localparam logic [31:0] EXC_ERET = 32'h0000000E;
  localparam logic [2:0]  FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL    = 16'(STALL_TIMEOUT);
  localparam bit          MULTI_FLUSH    = (FLUSH_CYCLES > 1);

  logic [0:0]  state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_timeout_q, stall_timeout_d;

  logic        exc_take;
  logic        flush_c;
  logic [5:0]  stall_c;
  logic [31:0] exc_pc;
  logic [31:0] new_pc_c;

  // Exceptions are only sampled in RUN; during FLUSH they are ignored.
  assign exc_take = (state_q == ST_RUN) && (bus.excepttype_i != 32'h0);
  assign exc_pc   = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
  assign flush_c  = exc_take || (state_q == ST_FLUSH);
  assign new_pc_c = exc_take ? exc_pc : new_pc_q;

  always_comb begin
    stall_c = 6'b000000;
    if (!flush_c) begin
      if (bus.stallreq_mem)     stall_c = 6'b011111;
      else if (bus.stallreq_ex) stall_c = 6'b001111;
      else if (bus.stallreq_id) stall_c = 6'b000111;
      else if (bus.stallreq_if) stall_c = 6'b000011;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc_take) begin
          new_pc_d = exc_pc;
          if (MULTI_FLUSH) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_CNT_INIT;
          end
        end
      end
      default: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end
      end
    endcase
  end

  // Watchdog counts consecutive PC-stall cycles and saturates at the limit.
  always_comb begin
    stall_cnt_d     = 16'd0;
    stall_timeout_d = stall_timeout_q;
    if (stall_c[0] && !flush_c) begin
      stall_cnt_d = (stall_cnt_q >= TIMEOUT_VAL) ? stall_cnt_q : stall_cnt_q + 16'd1;
      if (stall_cnt_d == TIMEOUT_VAL) stall_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      flush_cnt_q     <= 3'd0;
      new_pc_q        <= 32'h0;
      stall_cnt_q     <= 16'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      new_pc_q        <= new_pc_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // stall_c is already forced to zero in flush cycles, so those never count.
  always_comb begin
    perf_d = perf_q;
    if (stall_c != 6'b000000) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= 32'h0;
    else      perf_q <= perf_d;
  end

  assign bus.perf_stall_cycles = perf_q;
`else
  assign bus.perf_stall_cycles = 32'h0;
`endif

  // Requests are combinational, so gate them to keep every output at 0 in reset.
  assign bus.stall         = rst ? stall_c  : 6'b000000;
  assign bus.flush         = rst ? flush_c  : 1'b0;
  assign bus.new_pc        = rst ? new_pc_c : 32'h0;
  assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with FLUSH_CYCLES=1 (a), one with
// FLUSH_CYCLES=3 (b), both with STALL_TIMEOUT=8, driven from shared stimulus.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if ifa ();
  pipe_ctrl_if ifb ();

  assign ifa.stallreq_if  = s_if;
  assign ifa.stallreq_id  = s_id;
  assign ifa.stallreq_ex  = s_ex;
  assign ifa.stallreq_mem = s_mem;
  assign ifa.excepttype_i = exc;
  assign ifa.cp0_epc_i    = epc;
  assign ifb.stallreq_if  = s_if;
  assign ifb.stallreq_id  = s_id;
  assign ifb.stallreq_ex  = s_ex;
  assign ifb.stallreq_mem = s_mem;
  assign ifb.excepttype_i = exc;
  assign ifb.cp0_epc_i    = epc;

  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(1), .STALL_TIMEOUT(8))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(3), .STALL_TIMEOUT(8))
    u_b (.clk(clk), .rst(rst), .bus(ifb));

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic i_if, input logic i_id, input logic i_ex,
                       input logic i_mem, input logic [31:0] i_exc, input logic [31:0] i_epc);
    s_if = i_if; s_id = i_id; s_ex = i_ex; s_mem = i_mem; exc = i_exc; epc = i_epc;
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state: outputs zero even with requests pending.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
    chk("rst_stall", {26'h0, ifa.stall}, 32'h0);
    chk("rst_flush", {31'h0, ifa.flush}, 32'h0);
    chk("rst_new_pc", ifa.new_pc, 32'h0);
    chk("rst_timeout", {31'h0, ifa.stall_timeout}, 32'h0);
    chk("rst_perf", ifa.perf_stall_cycles, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    rst = 1'b1;

    // 1: load-use stall for three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("id_stall%0d", i), {26'h0, ifa.stall}, 32'h07);
      chk($sformatf("id_flush%0d", i), {31'h0, ifa.flush}, 32'h0);
    end
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("id_release", {26'h0, ifa.stall}, 32'h0);
    cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("if_only", {26'h0, ifa.stall}, 32'h03);
    cyc(); drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("ex_wins", {26'h0, ifa.stall}, 32'h0F);

    // 2: multiple requesters, deepest wins.
    cyc(); drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    chk("mem_wins", {26'h0, ifa.stall}, 32'h1F);

    // 3: exception with concurrent stall, single flush cycle.
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
    chk("exc_flush", {31'h0, ifa.flush}, 32'h1);
    chk("exc_stall", {26'h0, ifa.stall}, 32'h0);
    chk("exc_new_pc", ifa.new_pc, 32'hBFC00380);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("exc_done", {31'h0, ifa.flush}, 32'h0);
    chk("exc_pc_held", ifa.new_pc, 32'hBFC00380);
    pulse_rst();

    // 4: eret with three flush cycles, second exception ignored.
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hE, 32'h80001234);
    chk("eret_f1", {31'h0, ifb.flush}, 32'h1);
    chk("eret_pc1", ifb.new_pc, 32'h80001234);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
    chk("eret_f2", {31'h0, ifb.flush}, 32'h1);
    chk("eret_pc2", ifb.new_pc, 32'h80001234);
    chk("eret_st2", {26'h0, ifb.stall}, 32'h0);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("eret_f3", {31'h0, ifb.flush}, 32'h1);
    chk("eret_pc3", ifb.new_pc, 32'h80001234);
    cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("eret_run", {31'h0, ifb.flush}, 32'h0);
    chk("eret_run_st", {26'h0, ifb.stall}, 32'h07);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pulse_rst();

    // 5a: ten consecutive stall cycles trip the watchdog after the 8th edge.
    for (int i = 1; i <= 10; i++) begin
      cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk($sformatf("wd_c%0d", i), {31'h0, ifa.stall_timeout}, (i >= 9) ? 32'h1 : 32'h0);
    end
    chk("wd_stall", {26'h0, ifa.stall}, 32'h0F);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("wd_sticky", {31'h0, ifa.stall_timeout}, 32'h1);
    pulse_rst();
    chk("wd_cleared", {31'h0, ifa.stall_timeout}, 32'h0);

    // 5b: one-cycle gap at cycle 5 restarts the count.
    for (int i = 1; i <= 10; i++) begin
      cyc(); drive(1'b0, 1'b0, (i != 5), 1'b0, 32'h0, 32'h0);
    end
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("wd_gap", {31'h0, ifa.stall_timeout}, 32'h0);
    pulse_rst();

    // 6: five stall cycles then flush; reset mid-flush.
    for (int i = 0; i < 5; i++) begin
      cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("perf_f1", {31'h0, ifb.flush}, 32'h1);
    cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("perf_f2", {31'h0, ifb.flush}, 32'h1);
    chk("perf_cnt", ifb.perf_stall_cycles, PERF_EXP);
    rst = 1'b0;
    #1;
    chk("midrst_flush", {31'h0, ifb.flush}, 32'h0);
    chk("midrst_stall", {26'h0, ifb.stall}, 32'h0);
    chk("midrst_pc", ifb.new_pc, 32'h0);
    chk("midrst_perf", ifb.perf_stall_cycles, 32'h0);
    rst = 1'b1;
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midrst_run", {31'h0, ifb.flush}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
